// File: rtl/hist_pkg.sv
// rtl/hist_pkg.sv - shared defaults, FSM state type and saturating increment for the histogram engine
package hist_pkg;

    localparam int BIN_W_DEF   = 5;
    localparam int COUNT_W_DEF = 32;
    localparam int RD_LAT_DEF  = 2;

    typedef enum logic [1:0] {CLEAR, RUN, DRAIN} state_t;

    // Operates on a 64-bit container; w selects the live counter width.
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
        logic [63:0] top;
        top = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (v == top) ? v : v + 64'd1;
    endfunction

endpackage

// File: rtl/hist_if.sv
// rtl/hist_if.sv - sample stream carrying bin indices into the histogram engine
interface hist_if #(parameter int BIN_W = 5) ();

    logic             in_valid;
    logic             in_ready;
    logic [BIN_W-1:0] in_bin;

    modport master (output in_valid, output in_bin, input in_ready);
    modport slave  (input in_valid, input in_bin, output in_ready);

endinterface

// File: rtl/hist_fwd.sv
// rtl/hist_fwd.sv - write history of the last DEPTH cycles with youngest-match lookup
module hist_fwd #(
    parameter int BIN_W   = 5,
    parameter int COUNT_W = 32,
    parameter int DEPTH   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush_i,
    input  logic               push_i,
    input  logic [BIN_W-1:0]   push_bin_i,
    input  logic [COUNT_W-1:0] push_val_i,
    input  logic [BIN_W-1:0]   look_bin_i,
    output logic               hit_o,
    output logic [COUNT_W-1:0] val_o
);

    logic [DEPTH-1:0]   vld_q;
    logic [BIN_W-1:0]   bin_q [DEPTH];
    logic [COUNT_W-1:0] val_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                bin_q[i] <= '0;
                val_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= push_i && !flush_i;
            bin_q[0] <= push_bin_i;
            val_q[0] <= push_val_i;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1] && !flush_i;
                bin_q[i] <= bin_q[i-1];
                val_q[i] <= val_q[i-1];
            end
        end
    end

    // Scan oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        hit_o = 1'b0;
        val_o = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (vld_q[i] && (bin_q[i] == look_bin_i)) begin
                hit_o = 1'b1;
                val_o = val_q[i];
            end
        end
    end

endmodule

// File: rtl/hist_update.sv
// rtl/hist_update.sv - read-modify-write histogram engine driving a dual-port counter RAM
module hist_update
    import hist_pkg::*;
#(
    parameter int BIN_W   = BIN_W_DEF,
    parameter int COUNT_W = COUNT_W_DEF,
    parameter int RD_LAT  = RD_LAT_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    hist_if.slave              s_if,
    input  logic               clear_req_i,
    output logic               busy_o,
    output logic               clear_done_o,
    output logic [BIN_W-1:0]   ram_rdaddr_o,
    input  logic [COUNT_W-1:0] ram_q_i,
    output logic [BIN_W-1:0]   ram_wraddr_o,
    output logic [COUNT_W-1:0] ram_data_o,
    output logic               ram_wren_o
);

    localparam int NB = 2 ** BIN_W;

    state_t             state_q;
    logic [BIN_W:0]     ptr_q;
    logic               wren_q;
    logic               clear_done_q;
    logic [BIN_W-1:0]   wraddr_q;
    logic [COUNT_W-1:0] data_q;

    logic               accept;
    logic               tap_v;
    logic               pend;
    logic [BIN_W-1:0]   tap_b;
    logic               fwd_hit;
    logic [COUNT_W-1:0] fwd_val;
    logic [COUNT_W-1:0] base;
    logic [COUNT_W-1:0] inc_val;

    assign s_if.in_ready = (state_q == RUN) && !clear_req_i;
    assign accept        = s_if.in_valid && s_if.in_ready;
    assign ram_rdaddr_o  = accept ? s_if.in_bin : '0;

    // tap_* is the sample whose RAM data is on ram_q_i this cycle.
    generate
        if (RD_LAT == 1) begin : g_direct
            assign tap_v = accept;
            assign tap_b = s_if.in_bin;
            assign pend  = 1'b0;
        end else begin : g_pipe
            logic [RD_LAT-2:0] v_q;
            logic [BIN_W-1:0]  b_q [RD_LAT-1];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q <= '0;
                    for (int k = 0; k < RD_LAT - 1; k++) b_q[k] <= '0;
                end else begin
                    v_q[0] <= accept;
                    b_q[0] <= s_if.in_bin;
                    for (int k = 1; k < RD_LAT - 1; k++) begin
                        v_q[k] <= v_q[k-1];
                        b_q[k] <= b_q[k-1];
                    end
                end
            end

            assign tap_v = v_q[RD_LAT-2];
            assign tap_b = b_q[RD_LAT-2];
            assign pend  = |v_q;
        end
    endgenerate

    hist_fwd #(
        .BIN_W   (BIN_W),
        .COUNT_W (COUNT_W),
        .DEPTH   (RD_LAT)
    ) u_fwd (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (state_q == CLEAR),
        .push_i     (tap_v),
        .push_bin_i (tap_b),
        .push_val_i (inc_val),
        .look_bin_i (tap_b),
        .hit_o      (fwd_hit),
        .val_o      (fwd_val)
    );

    assign base    = fwd_hit ? fwd_val : ram_q_i;
    assign inc_val = COUNT_W'(sat_inc(64'(base), COUNT_W));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= CLEAR;
            ptr_q        <= '0;
            wren_q       <= 1'b0;
            wraddr_q     <= '0;
            data_q       <= '0;
            clear_done_q <= 1'b0;
        end else begin
            clear_done_q <= 1'b0;
            wren_q       <= tap_v;
            wraddr_q     <= tap_b;
            data_q       <= inc_val;
            case (state_q)
                CLEAR: begin
                    if (ptr_q == (BIN_W+1)'(NB)) begin
                        wren_q       <= 1'b0;
                        clear_done_q <= 1'b1;
                        ptr_q        <= '0;
                        state_q      <= RUN;
                    end else begin
                        wren_q   <= 1'b1;
                        wraddr_q <= ptr_q[BIN_W-1:0];
                        data_q   <= '0;
                        ptr_q    <= ptr_q + (BIN_W+1)'(1);
                    end
                end
                RUN: begin
                    if (clear_req_i) state_q <= DRAIN;
                end
                DRAIN: begin
                    // The last in-flight write is registered on this same edge.
                    if (!pend) begin
                        state_q <= CLEAR;
                        ptr_q   <= '0;
                    end
                end
                default: state_q <= CLEAR;
            endcase
        end
    end

    assign busy_o       = (state_q != RUN) || pend || wren_q;
    assign clear_done_o = clear_done_q;
    assign ram_wraddr_o = wraddr_q;
    assign ram_data_o   = data_q;
    assign ram_wren_o   = wren_q;

endmodule

// File: tb/tb_hist_update.sv
// tb/tb_hist_update.sv - scoreboard bench for the histogram read-modify-write engine
module tb_hist_update;
    import hist_pkg::*;

    typedef struct {
        int     addr;
        longint data;
        int     cyc;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rst_na, rst_nb, clr_a, clr_b;
    logic busy_a, busy_b, done_a, done_b, wea, web;
    logic [4:0]  rda, wra, rdb, wrb;
    logic [31:0] rq_a, da;
    logic [3:0]  rq_b, db;

    hist_if #(.BIN_W(5)) ifa ();
    hist_if #(.BIN_W(5)) ifb ();

    hist_update #(.BIN_W(5), .COUNT_W(32), .RD_LAT(2)) dut_a (
        .clk(clk), .rst_n(rst_na), .s_if(ifa), .clear_req_i(clr_a),
        .busy_o(busy_a), .clear_done_o(done_a), .ram_rdaddr_o(rda), .ram_q_i(rq_a),
        .ram_wraddr_o(wra), .ram_data_o(da), .ram_wren_o(wea)
    );

    hist_update #(.BIN_W(5), .COUNT_W(4), .RD_LAT(4)) dut_b (
        .clk(clk), .rst_n(rst_nb), .s_if(ifb), .clear_req_i(clr_b),
        .busy_o(busy_b), .clear_done_o(done_b), .ram_rdaddr_o(rdb), .ram_q_i(rq_b),
        .ram_wraddr_o(wrb), .ram_data_o(db), .ram_wren_o(web)
    );

    // RAM models: old data on read-during-write, q valid RD_LAT-1 cycles after the address.
    logic [31:0] mem_a [32];
    logic [3:0]  mem_b [32];
    logic [3:0]  rb1, rb2, rb3;
    always @(posedge clk) begin
        rq_a <= mem_a[rda];
        if (wea) mem_a[wra] <= da;
        rb1 <= mem_b[rdb];
        rb2 <= rb1;
        rb3 <= rb2;
        if (web) mem_b[wrb] <= db;
    end
    assign rq_b = rb3;

    int checks = 0;
    int errors = 0;
    wr_t sb_a[$];
    wr_t sb_b[$];
    wr_t ea, eb;
    int last_a = -1, last_a_cyc = -1, last_b = -1, last_b_cyc = -1;

    always @(negedge clk) begin
        if (wea) begin
            last_a = int'(wra);
            last_a_cyc = cyc;
            checks++;
            if (sb_a.size() == 0) begin
                errors++;
                $display("FAIL wr_a unexpected write addr %0d data %0d cycle %0d", wra, da, cyc);
            end else begin
                ea = sb_a.pop_front();
                if (ea.addr != int'(wra) || ea.data != longint'(da) || (ea.cyc >= 0 && ea.cyc != cyc)) begin
                    errors++;
                    $display("FAIL wr_a got addr %0d data %0d cycle %0d want addr %0d data %0d cycle %0d",
                             wra, da, cyc, ea.addr, ea.data, ea.cyc);
                end
            end
        end
        if (web) begin
            last_b = int'(wrb);
            last_b_cyc = cyc;
            checks++;
            if (sb_b.size() == 0) begin
                errors++;
                $display("FAIL wr_b unexpected write addr %0d data %0d cycle %0d", wrb, db, cyc);
            end else begin
                eb = sb_b.pop_front();
                if (eb.addr != int'(wrb) || eb.data != longint'(db) || (eb.cyc >= 0 && eb.cyc != cyc)) begin
                    errors++;
                    $display("FAIL wr_b got addr %0d data %0d cycle %0d want addr %0d data %0d cycle %0d",
                             wrb, db, cyc, eb.addr, eb.data, eb.cyc);
                end
            end
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic sweep_exp(input bit sel);
        for (int i = 0; i < 32; i++) begin
            if (sel) sb_b.push_back('{i, 0, -1});
            else     sb_a.push_back('{i, 0, -1});
        end
    endtask

    task automatic drive_a(input int b, input longint v);
        @(posedge clk); #1;
        ifa.in_valid = 1'b1;
        ifa.in_bin   = 5'(b);
        @(negedge clk);
        chk("in_ready_a", longint'(ifa.in_ready), 1);
        chk("rdaddr_a", longint'(rda), b);
        sb_a.push_back('{b, v, cyc + 2});
    endtask

    task automatic drive_b(input int b, input longint v);
        @(posedge clk); #1;
        ifb.in_valid = 1'b1;
        ifb.in_bin   = 5'(b);
        @(negedge clk);
        chk("in_ready_b", longint'(ifb.in_ready), 1);
        sb_b.push_back('{b, v, cyc + 4});
    endtask

    task automatic idle;
        @(posedge clk); #1;
        ifa.in_valid = 1'b0;
        ifb.in_valid = 1'b0;
    endtask

    task automatic wait_done(input bit sel, input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(sel ? done_b : done_a) && n < 300);
        chk({nm, "_clear_done"}, longint'(sel ? done_b : done_a), 1);
        chk({nm, "_last_sweep_addr"}, sel ? last_b : last_a, 31);
        chk({nm, "_last_sweep_cycle"}, sel ? last_b_cyc : last_a_cyc, cyc - 1);
        @(negedge clk);
        chk({nm, "_in_ready_after"}, longint'(sel ? ifb.in_ready : ifa.in_ready), 1);
    endtask

    int vals_59[5] = '{1, 1, 2, 2, 3};
    int bins_59[5] = '{5, 9, 5, 9, 5};

    initial begin
        int n;
        rst_na = 1'b0; rst_nb = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
        ifa.in_valid = 1'b0; ifa.in_bin = '0;
        ifb.in_valid = 1'b0; ifb.in_bin = '0;
        sweep_exp(1'b0);
        sweep_exp(1'b1);
        repeat (3) @(negedge clk);
        chk("rst_in_ready", longint'(ifa.in_ready), 0);
        chk("rst_busy", longint'(busy_a), 1);
        chk("rst_clear_done", longint'(done_a), 0);
        chk("rst_wren", longint'(wea), 0);
        chk("rst_wraddr", longint'(wra), 0);
        chk("rst_data", longint'(da), 0);
        chk("rst_rdaddr", longint'(rda), 0);
        @(posedge clk); #1;
        rst_na = 1'b1;
        wait_done(1'b0, "sweep0");

        drive_a(3, 1);
        idle();
        @(negedge clk);
        @(negedge clk);
        chk("busy_t2", longint'(busy_a), 1);
        @(negedge clk);
        chk("busy_t3", longint'(busy_a), 0);

        for (int i = 0; i < 4; i++) drive_a(7, i + 1);
        idle();
        repeat (4) @(negedge clk);
        drive_a(7, 5);
        idle();
        repeat (4) @(negedge clk);

        for (int i = 0; i < 5; i++) drive_a(bins_59[i], vals_59[i]);
        idle();
        repeat (4) @(negedge clk);

        drive_a(3, 2);
        drive_a(9, 3);
        @(posedge clk); #1;
        ifa.in_bin = 5'd12;
        clr_a = 1'b1;
        @(negedge clk);
        chk("clear_req_in_ready", longint'(ifa.in_ready), 0);
        sweep_exp(1'b0);
        @(posedge clk); #1;
        clr_a = 1'b0;
        ifa.in_valid = 1'b0;
        wait_done(1'b0, "sweep1");
        drive_a(3, 1);
        idle();
        repeat (4) @(negedge clk);

        last_a = -1;
        @(posedge clk); #1;
        clr_a = 1'b1;
        @(posedge clk); #1;
        clr_a = 1'b0;
        sweep_exp(1'b0);
        n = 0;
        while (last_a != 10 && n < 300) begin
            @(posedge clk);
            n++;
        end
        chk("midsweep_reached_addr10", last_a, 10);
        #1;
        rst_na = 1'b0;
        sb_a.delete();
        sweep_exp(1'b0);
        @(negedge clk);
        chk("midsweep_rst_wren", longint'(wea), 0);
        chk("midsweep_rst_busy", longint'(busy_a), 1);
        @(posedge clk); #1;
        rst_na = 1'b1;
        wait_done(1'b0, "sweep2");
        drive_a(20, 1);
        idle();
        repeat (4) @(negedge clk);

        @(posedge clk); #1;
        rst_nb = 1'b1;
        wait_done(1'b1, "sweep_b");
        for (int i = 0; i < 17; i++) drive_b(0, (i < 15) ? i + 1 : 15);
        idle();
        repeat (8) @(negedge clk);
        chk("sat_final_ram0", longint'(mem_b[0]), 15);

        repeat (5) @(negedge clk);
        chk("sb_a_drained", sb_a.size(), 0);
        chk("sb_b_drained", sb_b.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
